// File: rtl/reg_bank_pkg.sv
// Shared constants and FSM state type for the 16-entry register bank.
package reg_bank_pkg;
    localparam int unsigned NUM_REGS       = 16;
    localparam int unsigned SEL_W          = 4;
    localparam int unsigned DEFAULT_DATA_W = 16;

    typedef enum logic {
        IDLE,
        CLEAR
    } state_t;
endpackage

// File: rtl/decoder4_16.sv
// Combinational 4-to-16 one-hot decoder with enable.
module decoder4_16
    import reg_bank_pkg::*;
(
    input  logic [SEL_W-1:0]    idx,
    input  logic                en,
    output logic [NUM_REGS-1:0] onehot
);

    always_comb begin
        onehot = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank16.sv
// Sixteen-entry register bank with valid/ready write port and a sequential bulk clear.
module reg_bank16
    import reg_bank_pkg::*;
#(
    parameter int unsigned DATA_W   = reg_bank_pkg::DEFAULT_DATA_W,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [SEL_W-1:0]  wr_sel,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_done,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [DATA_W-1:0] out0,
    output logic [DATA_W-1:0] out1,
    output logic [DATA_W-1:0] out2,
    output logic [DATA_W-1:0] out3,
    output logic [DATA_W-1:0] out4,
    output logic [DATA_W-1:0] out5,
    output logic [DATA_W-1:0] out6,
    output logic [DATA_W-1:0] out7,
    output logic [DATA_W-1:0] out8,
    output logic [DATA_W-1:0] out9,
    output logic [DATA_W-1:0] out10,
    output logic [DATA_W-1:0] out11,
    output logic [DATA_W-1:0] out12,
    output logic [DATA_W-1:0] out13,
    output logic [DATA_W-1:0] out14,
    output logic [DATA_W-1:0] out15
);

    state_t              state, state_nxt;
    logic [SEL_W-1:0]    cnt, cnt_nxt;
    logic                wr_accept;
    logic [NUM_REGS-1:0] wr_en, clr_en, ld_en;
    logic [DATA_W-1:0]   regs [NUM_REGS];

    assign wr_accept = wr_valid && wr_ready;

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                cnt_nxt = cnt + 1'b1;
                if (cnt == SEL_W'(NUM_REGS - 1)) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Handshake flags are registered from the next state so they read 0 during reset
    // yet still track the state register exactly once running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            wr_ready <= 1'b0;
            clr_busy <= 1'b0;
            wr_done  <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            wr_ready <= (state_nxt == IDLE);
            clr_busy <= (state_nxt == CLEAR);
            wr_done  <= wr_accept;
        end
    end

    decoder4_16 u_wr_dec (
        .idx    (wr_sel),
        .en     (wr_accept),
        .onehot (wr_en)
    );

    decoder4_16 u_clr_dec (
        .idx    (cnt),
        .en     (state == CLEAR),
        .onehot (clr_en)
    );

    always_comb begin
        ld_en = wr_en | clr_en;
        if (ZERO_REG) begin
            ld_en[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (ld_en[i]) begin
                    regs[i] <= clr_en[i] ? '0 : wr_data;
                end
            end
        end
    end

    assign out0  = regs[0];
    assign out1  = regs[1];
    assign out2  = regs[2];
    assign out3  = regs[3];
    assign out4  = regs[4];
    assign out5  = regs[5];
    assign out6  = regs[6];
    assign out7  = regs[7];
    assign out8  = regs[8];
    assign out9  = regs[9];
    assign out10 = regs[10];
    assign out11 = regs[11];
    assign out12 = regs[12];
    assign out13 = regs[13];
    assign out14 = regs[14];
    assign out15 = regs[15];

endmodule

// File: tb/tb_reg_bank16.sv
// Directed, table-driven checks for reg_bank16 plus hand-written clear/reset sequences.
module tb_reg_bank16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [3:0]  wr_sel;
    logic [15:0] wr_data;
    logic        wr_done;
    logic        clr_req;
    logic        clr_busy;
    logic [15:0] o [16];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_bank16 #(.DATA_W(16), .ZERO_REG(1'b1)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_sel   (wr_sel),
        .wr_data  (wr_data),
        .wr_done  (wr_done),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .out0  (o[0]),  .out1  (o[1]),  .out2  (o[2]),  .out3  (o[3]),
        .out4  (o[4]),  .out5  (o[5]),  .out6  (o[6]),  .out7  (o[7]),
        .out8  (o[8]),  .out9  (o[9]),  .out10 (o[10]), .out11 (o[11]),
        .out12 (o[12]), .out13 (o[13]), .out14 (o[14]), .out15 (o[15])
    );

    typedef struct {
        logic [3:0]  sel;
        logic [15:0] data;
        int          chk_idx;
        logic [15:0] chk_val;
        int          oth_idx;
        logic [15:0] oth_val;
    } wvec_t;

    wvec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] or_all();
        logic [15:0] acc;
        acc = '0;
        for (int i = 0; i < 16; i++) acc = acc | o[i];
        return acc;
    endfunction

    initial begin
        int busy_cnt;

        vecs[0] = '{4'd5,  16'hA5A5, 5,  16'hA5A5, 15, 16'h0000};
        vecs[1] = '{4'd1,  16'h0001, 1,  16'h0001, 5,  16'hA5A5};
        vecs[2] = '{4'd15, 16'hFFFF, 15, 16'hFFFF, 1,  16'h0001};
        vecs[3] = '{4'd1,  16'h1234, 1,  16'h1234, 15, 16'hFFFF};
        vecs[4] = '{4'd0,  16'hBEEF, 0,  16'h0000, 1,  16'h1234};

        rst_n = 1'b0; wr_valid = 1'b0; wr_sel = '0; wr_data = '0; clr_req = 1'b0;
        #12;
        check("rst_ready", 32'(wr_ready), 32'd0);
        check("rst_busy",  32'(clr_busy), 32'd0);
        check("rst_done",  32'(wr_done),  32'd0);
        check("rst_outs",  32'(or_all()), 32'd0);
        rst_n = 1'b1;
        step();
        check("post_rst_ready", 32'(wr_ready), 32'd1);
        check("post_rst_busy",  32'(clr_busy), 32'd0);

        // back-to-back writes, one per cycle
        for (int v = 0; v < 5; v++) begin
            wr_valid = 1'b1; wr_sel = vecs[v].sel; wr_data = vecs[v].data;
            step();
            check($sformatf("wr%0d_done", v), 32'(wr_done), 32'd1);
            check($sformatf("wr%0d_out", v), 32'(o[vecs[v].chk_idx]), 32'(vecs[v].chk_val));
            check($sformatf("wr%0d_other", v), 32'(o[vecs[v].oth_idx]), 32'(vecs[v].oth_val));
        end
        wr_valid = 1'b0;
        step();
        check("done_drop", 32'(wr_done), 32'd0);
        check("untouched2", 32'(o[2]), 32'd0);

        // fill all entries, then sweep with a write held pending
        for (int i = 0; i < 16; i++) begin
            wr_valid = 1'b1; wr_sel = 4'(i); wr_data = 16'(16'h1000 + i + 1);
            step();
        end
        wr_valid = 1'b0;
        check("fill0_zero", 32'(o[0]), 32'd0);
        check("fill9", 32'(o[9]), 32'h100A);
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        wr_valid = 1'b1; wr_sel = 4'd9; wr_data = 16'h9999;
        busy_cnt = 0;
        if (clr_busy) busy_cnt++;
        check("sweep_start_ready", 32'(wr_ready), 32'd0);
        for (int k = 0; k < 16; k++) begin
            step();
            if (clr_busy) busy_cnt++;
            check($sformatf("sweep_zero%0d", k), 32'(o[k]), 32'd0);
            if (k < 15) begin
                check($sformatf("sweep_hold%0d", k + 1), 32'(o[k + 1]), 32'(16'h1000 + k + 2));
                check($sformatf("sweep_ready%0d", k), 32'(wr_ready), 32'd0);
                check($sformatf("sweep_done%0d", k), 32'(wr_done), 32'd0);
            end
        end
        check("busy_cycles", 32'(busy_cnt), 32'd16);
        check("sweep_end_ready", 32'(wr_ready), 32'd1);
        check("sweep_end_busy", 32'(clr_busy), 32'd0);
        step();
        check("held_wr_done", 32'(wr_done), 32'd1);
        check("held_wr_out", 32'(o[9]), 32'h9999);
        wr_valid = 1'b0;

        // write and clear on the same edge; clr_req held into the sweep is ignored
        wr_valid = 1'b1; wr_sel = 4'd3; wr_data = 16'h7777; clr_req = 1'b1;
        step();
        wr_valid = 1'b0;
        check("sim_done", 32'(wr_done), 32'd1);
        check("sim_out3", 32'(o[3]), 32'h7777);
        check("sim_busy", 32'(clr_busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("sim_keep3_%0d", k), 32'(o[3]), 32'h7777);
        end
        step();
        clr_req = 1'b0;
        check("sim_zero3", 32'(o[3]), 32'd0);
        for (int k = 4; k < 15; k++) step();
        check("sim_busy_last", 32'(clr_busy), 32'd1);
        step();
        check("sim_busy_end", 32'(clr_busy), 32'd0);
        check("sim_all_zero", 32'(or_all()), 32'd0);

        // reset in the middle of a sweep
        wr_valid = 1'b1; wr_sel = 4'd12; wr_data = 16'h0C0C;
        step();
        wr_sel = 4'd8; wr_data = 16'h0808;
        step();
        wr_valid = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int k = 0; k < 8; k++) step();
        check("mid_keep8", 32'(o[8]), 32'h0808);
        rst_n = 1'b0;
        #1;
        check("mid_rst_outs",  32'(or_all()), 32'd0);
        check("mid_rst_busy",  32'(clr_busy), 32'd0);
        check("mid_rst_ready", 32'(wr_ready), 32'd0);
        #2;
        rst_n = 1'b1;
        step();
        check("mid_rel_ready", 32'(wr_ready), 32'd1);
        check("mid_rel_busy",  32'(clr_busy), 32'd0);
        wr_valid = 1'b1; wr_sel = 4'd14; wr_data = 16'h1414;
        step();
        wr_valid = 1'b0;
        for (int k = 0; k < 10; k++) step();
        check("no_resume_out14", 32'(o[14]), 32'h1414);
        check("no_resume_busy",  32'(clr_busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
